// File: rtl/adder_arbiter_if.sv
// Requester-side bundle of the shared-adder arbiter: request levels, flattened
// operands, grant/done handshake and the returned sum/carry.
interface adder_arbiter_if #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned WIDTH = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  carry;
  logic                  busy;

  modport master (
    output req, op_a, op_b,
    input  gnt, done, result, carry, busy
  );

  modport slave (
    input  req, op_a, op_b,
    output gnt, done, result, carry, busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one combinational adder among NREQ requesters.
// Optional macro ADDER_ARB_PRIO0_EN gives requester 0 absolute priority.
module adder_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  adder_arbiter_if.slave    bus,
  output logic [WIDTH-1:0]  adder_in1,
  output logic [WIDTH-1:0]  adder_in2,
  input  logic [WIDTH-1:0]  adder_out,
  input  logic              adder_carry
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  idx_t              rr_ptr;
  idx_t              rr_ptr_d;
  idx_t              cur_idx;
  idx_t              cur_idx_d;
  idx_t              win_idx;
  idx_t              rr_wrap;
  logic              win_found;
  int unsigned       scan_idx;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   gnt_d;
  logic [NREQ-1:0]   done_q;
  logic [NREQ-1:0]   done_d;
  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  result_d;
  logic [WIDTH-1:0]  in1_q;
  logic [WIDTH-1:0]  in1_d;
  logic [WIDTH-1:0]  in2_q;
  logic [WIDTH-1:0]  in2_d;
  logic              carry_q;
  logic              carry_d;
  logic              busy_q;
  logic [WIDTH-1:0]  op_a_arr [NREQ];
  logic [WIDTH-1:0]  op_b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_a_arr[i] = bus.op_a[i*WIDTH +: WIDTH];
    assign op_b_arr[i] = bus.op_b[i*WIDTH +: WIDTH];
  end

  // Winner: first set request at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = (32'(rr_ptr) + k) % NREQ;
      if (!win_found && bus.req[idx_t'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = idx_t'(scan_idx);
      end
    end
`ifdef ADDER_ARB_PRIO0_EN
    if (bus.req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_comb begin
    rr_wrap = (32'(cur_idx) == NREQ - 1) ? '0 : cur_idx + idx_t'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values; operands are frozen at grant.
  always_comb begin
    gnt_d     = gnt_q;
    done_d    = '0;
    result_d  = result_q;
    carry_d   = carry_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    cur_idx_d = cur_idx;
    rr_ptr_d  = rr_ptr;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_d     = NREQ'(1) << win_idx;
          in1_d     = op_a_arr[win_idx];
          in2_d     = op_b_arr[win_idx];
          cur_idx_d = win_idx;
        end
      end
      EXEC: begin
        result_d = adder_out;
        carry_d  = adder_carry;
        done_d   = gnt_q;
      end
      DONE: begin
        gnt_d = '0;
`ifdef ADDER_ARB_PRIO0_EN
        if (cur_idx != '0) rr_ptr_d = rr_wrap;
`else
        rr_ptr_d = rr_wrap;
`endif
      end
      default: gnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      cur_idx  <= '0;
      rr_ptr   <= '0;
      busy_q   <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      cur_idx  <= cur_idx_d;
      rr_ptr   <= rr_ptr_d;
      busy_q   <= (state_next != IDLE);
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.busy   = busy_q;
  assign adder_in1  = in1_q;
  assign adder_in2  = in2_q;

  // Grant is one-hot and done only ever marks the granted requester.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_q));
  a_done_in_gnt: assert property (@(posedge clk) disable iff (!reset) (done_q & ~gnt_q) == '0);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level model compared every cycle plus
// directed checks with literal expectations; honours ADDER_ARB_PRIO0_EN.
module tb_adder_arbiter;
  localparam int unsigned NREQ  = 3;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] adder_in1;
  logic [WIDTH-1:0] adder_in2;
  logic [WIDTH-1:0] adder_out;
  logic             adder_carry;
  int               n_cmp = 0;
  int               n_fail = 0;
  int               cyc = 0;
  logic             chk_en = 1'b0;

  adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .adder_in1   (adder_in1),
    .adder_in2   (adder_in2),
    .adder_out   (adder_out),
    .adder_carry (adder_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The shared adder itself.
  assign {adder_carry, adder_out} = {1'b0, adder_in1} + {1'b0, adder_in2};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] slice(input logic [NREQ*WIDTH-1:0] v, input int unsigned i);
    return WIDTH'(v >> (i * WIDTH));
  endfunction

  function automatic int unsigned pick(input logic [NREQ-1:0] r, input int unsigned rr);
    int unsigned j;
    pick = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (rr + k) % NREQ;
      if (((r >> j) & NREQ'(1)) != '0) pick = j;
    end
`ifdef ADDER_ARB_PRIO0_EN
    if (r[0]) pick = 0;
`endif
  endfunction

  // Transaction model: a grant starts a 3-cycle transaction whose sum is the
  // plain WIDTH+1-bit addition of the operands present at grant.
  logic [NREQ-1:0]  e_gnt, e_done;
  logic [WIDTH-1:0] e_result, e_in1, e_in2;
  logic             e_carry, e_busy;
  logic [WIDTH:0]   m_sum;
  int unsigned      m_left, m_w, m_rr, m_pick;

  assign m_pick = pick(bus.req, m_rr);

  always @(posedge clk) begin
    if (!reset) begin
      e_gnt <= '0; e_done <= '0; e_busy <= 1'b0; e_result <= '0; e_carry <= 1'b0;
      e_in1 <= '0; e_in2 <= '0; m_left <= 0; m_rr <= 0; m_w <= 0; m_sum <= '0;
    end else if (m_left == 0) begin
      if (bus.req != '0) begin
        m_w    <= m_pick;
        m_left <= 2;
        e_gnt  <= NREQ'(1) << m_pick;
        e_busy <= 1'b1;
        e_in1  <= slice(bus.op_a, m_pick);
        e_in2  <= slice(bus.op_b, m_pick);
        m_sum  <= {1'b0, slice(bus.op_a, m_pick)} + {1'b0, slice(bus.op_b, m_pick)};
      end
    end else if (m_left == 2) begin
      e_result <= m_sum[WIDTH-1:0];
      e_carry  <= m_sum[WIDTH];
      e_done   <= e_gnt;
      m_left   <= 1;
    end else begin
      e_done <= '0;
      e_gnt  <= '0;
      e_busy <= 1'b0;
      m_left <= 0;
`ifdef ADDER_ARB_PRIO0_EN
      if (m_w != 0) m_rr <= (m_w + 1) % NREQ;
`else
      m_rr <= (m_w + 1) % NREQ;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_gnt",    64'(bus.gnt),    64'(e_gnt));
      check("m_done",   64'(bus.done),   64'(e_done));
      check("m_busy",   64'(bus.busy),   64'(e_busy));
      check("m_result", 64'(bus.result), 64'(e_result));
      check("m_carry",  64'(bus.carry),  64'(e_carry));
      check("m_in1",    64'(adder_in1),  64'(e_in1));
      check("m_in2",    64'(adder_in2),  64'(e_in2));
    end
  end

  task automatic wait_done(output logic [NREQ-1:0] d, output int t);
    d = '0;
    for (int i = 0; i < 20 && d == '0; i++) begin
      @(negedge clk);
      d = bus.done;
    end
    t = cyc;
    if (d == '0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done within 20 cycles, expected a pulse");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ-1:0]  d;
    int               tm;
    int               prev_tm;
    int unsigned      exp_w;
    logic [WIDTH-1:0] lit_res [NREQ];
    logic             lit_cry [NREQ];

    reset    = 1'b0;
    bus.req  = 3'b111;
    bus.op_a = {32'hFFFF_FFFF, 32'h0000_0004, 32'h0000_0001};
    bus.op_b = {32'h0000_0001, 32'h0040_0000, 32'h0000_0002};
    lit_res[0] = 32'h0000_0003; lit_cry[0] = 1'b0;
    lit_res[1] = 32'h0040_0004; lit_cry[1] = 1'b0;
    lit_res[2] = 32'h0000_0000; lit_cry[2] = 1'b1;

    // Reset held two edges with all requests high.
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_gnt",    64'(bus.gnt),    64'h0);
    check("rst_done",   64'(bus.done),   64'h0);
    check("rst_busy",   64'(bus.busy),   64'h0);
    check("rst_result", 64'(bus.result), 64'h0);
    check("rst_carry",  64'(bus.carry),  64'h0);
    reset = 1'b1;
    @(negedge clk);
    check("first_gnt", 64'(bus.gnt), 64'h1);

    // Round robin, each requester dropping on its done.
    for (int t = 0; t < 3; t++) begin
      wait_done(d, tm);
      check("rr_drop_order", 64'(d), 64'(NREQ'(1) << t));
      check("rr_drop_result", 64'(bus.result), 64'(lit_res[t]));
      check("rr_drop_carry", 64'(bus.carry), 64'(lit_cry[t]));
      bus.req = bus.req & ~d;
    end

    // Single add on requester 1.
    @(negedge clk);
    bus.req = 3'b010;
    @(negedge clk);
    check("single_gnt", 64'(bus.gnt), 64'h2);
    check("single_nodone", 64'(bus.done), 64'h0);
    wait_done(d, tm);
    check("single_done", 64'(d), 64'h2);
    check("single_result", 64'(bus.result), 64'h0040_0004);
    check("single_carry", 64'(bus.carry), 64'h0);
    bus.req = '0;

    // Carry-out on requester 2; operands changed after grant must not matter.
    @(negedge clk);
    bus.op_a[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
    bus.op_b[2*WIDTH +: WIDTH] = 32'h0000_0001;
    bus.req = 3'b100;
    @(negedge clk);
    check("carry_gnt", 64'(bus.gnt), 64'h4);
    bus.op_a[2*WIDTH +: WIDTH] = 32'h0000_1000;
    bus.op_b[2*WIDTH +: WIDTH] = 32'h0000_1234;
    wait_done(d, tm);
    check("carry_done", 64'(d), 64'h4);
    check("carry_result", 64'(bus.result), 64'h0);
    check("carry_carry", 64'(bus.carry), 64'h1);
    bus.req = '0;

    // All requesters re-asserting: order and 3-cycle spacing.
    @(negedge clk);
    bus.op_a = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    bus.op_b = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    lit_res[0] = 32'h1000_0001;
    lit_res[1] = 32'h2000_0002;
    lit_res[2] = 32'h3000_0003;
    bus.req = 3'b111;
    prev_tm = 0;
    for (int t = 0; t < 6; t++) begin
`ifdef ADDER_ARB_PRIO0_EN
      exp_w = 0;
`else
      exp_w = t % 3;
`endif
      wait_done(d, tm);
      check("rr_hold_order", 64'(d), 64'(NREQ'(1) << exp_w));
      check("rr_hold_result", 64'(bus.result), 64'(lit_res[exp_w]));
      if (t > 0) check("rr_hold_spacing", 64'(tm - prev_tm), 64'd3);
      prev_tm = tm;
    end
    bus.req = '0;

    // Move rr_ptr off zero, then reset in the middle of a transaction.
    @(negedge clk);
    bus.req = 3'b001;
    wait_done(d, tm);
    check("pre_rst_done", 64'(d), 64'h1);
    bus.req = '0;
    @(negedge clk);
    bus.req = 3'b011;
    @(negedge clk);
`ifdef ADDER_ARB_PRIO0_EN
    check("midrst_gnt", 64'(bus.gnt), 64'h1);
`else
    check("midrst_gnt", 64'(bus.gnt), 64'h2);
`endif
    reset = 1'b0;
    @(negedge clk);
    check("midrst_done", 64'(bus.done), 64'h0);
    check("midrst_gnt0", 64'(bus.gnt), 64'h0);
    check("midrst_busy", 64'(bus.busy), 64'h0);
    check("midrst_result", 64'(bus.result), 64'h0);
    check("midrst_carry", 64'(bus.carry), 64'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rearb_gnt", 64'(bus.gnt), 64'h1);
    wait_done(d, tm);
    check("rearb_done", 64'(d), 64'h1);
    check("rearb_result", 64'(bus.result), 64'h1000_0001);
    bus.req = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
